rvh_l1d_refill_asm: RTL and testbench

- Downstream of the L1D MSHR: consumes L2 read-response beats tagged with an MSHR id and assembles them into a full 512-bit line.
- Presents the finished line to the bank refill port, then issues the MSHR dealloc (idx + valid) that frees the entry.
- Single assembly buffer: one refill in flight; L2 is back-pressured via rready while busy.

---
 rtl/rvh_l1d_refill_asm.sv | 143 ++++++++++++++
 tb/tb_rvh_l1d_refill_asm.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rvh_l1d_refill_asm.sv
// L1D refill assembler: collects L2 response beats into one cache line, hands it to the bank, then frees the MSHR.
// Optional beat-count checking is enabled by defining RVH_L1D_REFILL_BEAT_CHK_EN.
module rvh_l1d_refill_asm #(
  parameter int unsigned LINE_W = 512,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned N_MSHR = 4,
  localparam int unsigned N_BEAT = LINE_W / BEAT_W,
  localparam int unsigned ID_W   = (N_MSHR > 1) ? $clog2(N_MSHR) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l2_resp_if_rvalid,
  output logic              l2_resp_if_rready,
  input  logic [ID_W-1:0]   l2_resp_if_rid,
  input  logic [BEAT_W-1:0] l2_resp_if_rdata,
  input  logic              l2_resp_if_rlast,
  input  logic [N_MSHR-1:0] mshr_bank_valid_i,
  input  logic [N_MSHR-1:0] mshr_bank_no_resp_i,
  output logic              refill_valid_o,
  input  logic              refill_ready_i,
  output logic [ID_W-1:0]   refill_mshr_id_o,
  output logic [LINE_W-1:0] refill_line_o,
  output logic              refill_no_resp_o,
  output logic              mlfb_mshr_dealloc_valid_o,
  output logic [ID_W-1:0]   mlfb_mshr_dealloc_idx_o,
  input  logic              mlfb_mshr_dealloc_ready_i,
  output logic              refill_err_o
);

  localparam int unsigned CNT_W = (N_BEAT > 1) ? $clog2(N_BEAT) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_BEAT - 1);

`ifdef RVH_L1D_REFILL_BEAT_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_REFILL,
    S_DEALLOC
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [CNT_W-1:0]  slot;
  logic [CNT_W-1:0]  slot_inc;
  logic [ID_W-1:0]   cur_id_q;
  logic [LINE_W-1:0] line_q;
  logic              orphan_q;
  logic              accept;
  logic              close;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d                   = state_q;
    l2_resp_if_rready         = 1'b0;
    refill_valid_o            = 1'b0;
    mlfb_mshr_dealloc_valid_o = 1'b0;
    accept                    = 1'b0;
    close                     = 1'b0;
    slot                      = (state_q == S_COLLECT) ? beat_cnt_q : '0;
    slot_inc                  = (slot == LAST_SLOT) ? '0 : slot + CNT_W'(1);

    case (state_q)
      S_IDLE, S_COLLECT: begin
        l2_resp_if_rready = 1'b1;
        accept            = l2_resp_if_rvalid;
        // With checking on, a line is forcibly closed once the last slot is filled.
        close             = accept && (l2_resp_if_rlast || (CHK_EN && (slot == LAST_SLOT)));
        if (close) begin
          state_d = S_REFILL;
        end else if (accept) begin
          state_d = S_COLLECT;
        end
      end
      S_REFILL: begin
        refill_valid_o = 1'b1;
        if (refill_ready_i) begin
          state_d = orphan_q ? S_IDLE : S_DEALLOC;
        end
      end
      S_DEALLOC: begin
        mlfb_mshr_dealloc_valid_o = 1'b1;
        if (mlfb_mshr_dealloc_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the line buffer is reset as well, so an aborted refill never leaks stale data to the bank.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      cur_id_q   <= '0;
      orphan_q   <= 1'b0;
      line_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        beat_cnt_q <= close ? '0 : slot_inc;
        if (state_q == S_IDLE) begin
          // Clearing on the first beat gives zero-filled tail slots on an early rlast.
          cur_id_q <= l2_resp_if_rid;
          orphan_q <= !mshr_bank_valid_i[l2_resp_if_rid];
          line_q   <= '0;
        end
        line_q[slot * BEAT_W +: BEAT_W] <= l2_resp_if_rdata;
      end
    end
  end

  assign refill_mshr_id_o        = cur_id_q;
  assign refill_line_o           = line_q;
  assign refill_no_resp_o        = (state_q == S_REFILL) && mshr_bank_no_resp_i[cur_id_q];
  assign mlfb_mshr_dealloc_idx_o = cur_id_q;

`ifdef RVH_L1D_REFILL_BEAT_CHK_EN
  logic err_q;
  logic beat_err;

  assign beat_err = accept && (l2_resp_if_rlast != (slot == LAST_SLOT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (beat_err) begin
      err_q <= 1'b1;
    end
  end

  assign refill_err_o = err_q;
`else
  assign refill_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rvh_l1d_refill_asm.sv
// Directed bench for rvh_l1d_refill_asm: expected refills are queued as lines are sent and checked when the DUT presents them.
module tb_rvh_l1d_refill_asm;

  localparam int LINE_W = 512;
  localparam int BEAT_W = 64;
  localparam int N_MSHR = 4;
  localparam int N_BEAT = LINE_W / BEAT_W;
  localparam int ID_W   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rvalid = 1'b0;
  logic              rready;
  logic [ID_W-1:0]   rid = '0;
  logic [BEAT_W-1:0] rdata = '0;
  logic              rlast = 1'b0;
  logic [N_MSHR-1:0] mshr_valid = '0;
  logic [N_MSHR-1:0] mshr_no_resp = '0;
  logic              refill_valid;
  logic              refill_ready = 1'b0;
  logic [ID_W-1:0]   refill_id;
  logic [LINE_W-1:0] refill_line;
  logic              refill_no_resp;
  logic              dealloc_valid;
  logic [ID_W-1:0]   dealloc_idx;
  logic              dealloc_ready = 1'b0;
  logic              refill_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [LINE_W-1:0] line;
    logic              no_resp;
    bit                dealloc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rvh_l1d_refill_asm dut (
    .clk                       (clk),
    .rst                       (rst),
    .l2_resp_if_rvalid         (rvalid),
    .l2_resp_if_rready         (rready),
    .l2_resp_if_rid            (rid),
    .l2_resp_if_rdata          (rdata),
    .l2_resp_if_rlast          (rlast),
    .mshr_bank_valid_i         (mshr_valid),
    .mshr_bank_no_resp_i       (mshr_no_resp),
    .refill_valid_o            (refill_valid),
    .refill_ready_i            (refill_ready),
    .refill_mshr_id_o          (refill_id),
    .refill_line_o             (refill_line),
    .refill_no_resp_o          (refill_no_resp),
    .mlfb_mshr_dealloc_valid_o (dealloc_valid),
    .mlfb_mshr_dealloc_idx_o   (dealloc_idx),
    .mlfb_mshr_dealloc_ready_i (dealloc_ready),
    .refill_err_o              (refill_err)
  );

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one beat, waiting (bounded) for rready; returns #1 after the accepting edge.
  task automatic send_beat(input logic [ID_W-1:0] id, input logic [BEAT_W-1:0] data, input logic last);
    int waited = 0;
    rvalid = 1'b1;
    rid    = id;
    rdata  = data;
    rlast  = last;
    #1;
    while (!rready && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) check("rready_timeout", LINE_W'(rready), LINE_W'(1));
    tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic send_line(input logic [ID_W-1:0] id, input logic [BEAT_W-1:0] base, input int n_beats,
                           input bit with_last, input logic exp_no_resp, input bit exp_dealloc, input bit push);
    exp_t e;
    e.id      = id;
    e.line    = '0;
    e.no_resp = exp_no_resp;
    e.dealloc = exp_dealloc;
    for (int k = 0; k < n_beats; k++) e.line[k*BEAT_W +: BEAT_W] = base + BEAT_W'(k);
    if (push) sb.push_back(e);
    for (int k = 0; k < n_beats; k++) begin
      send_beat(id, base + BEAT_W'(k), with_last && (k == n_beats - 1));
    end
  endtask

  // Waits for the refill, compares it to the scoreboard head, then completes both handshakes.
  task automatic finish_refill(output int waited);
    exp_t e;
    waited = 0;
    while (!refill_valid && waited < 50) begin
      tick();
      waited++;
    end
    check("refill_valid", LINE_W'(refill_valid), LINE_W'(1));
    check("sb_nonempty", LINE_W'(sb.size() > 0), LINE_W'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("refill_id", LINE_W'(refill_id), LINE_W'(e.id));
      check("refill_line", refill_line, e.line);
      check("refill_no_resp", LINE_W'(refill_no_resp), LINE_W'(e.no_resp));
      check("rready_in_refill", LINE_W'(rready), LINE_W'(0));
      refill_ready = 1'b1;
      tick();
      refill_ready = 1'b0;
      check("refill_valid_drop", LINE_W'(refill_valid), LINE_W'(0));
      if (e.dealloc) begin
        check("dealloc_valid", LINE_W'(dealloc_valid), LINE_W'(1));
        check("dealloc_idx", LINE_W'(dealloc_idx), LINE_W'(e.id));
        dealloc_ready = 1'b1;
        tick();
        dealloc_ready = 1'b0;
      end
      check("dealloc_clear", LINE_W'(dealloc_valid), LINE_W'(0));
      check("rready_idle", LINE_W'(rready), LINE_W'(1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    exp_t head;

    // Reset
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_refill_valid", LINE_W'(refill_valid), LINE_W'(0));
    check("rst_dealloc_valid", LINE_W'(dealloc_valid), LINE_W'(0));
    check("rst_rready", LINE_W'(rready), LINE_W'(1));
    check("rst_err", LINE_W'(refill_err), LINE_W'(0));
    check("rst_id", LINE_W'(refill_id), LINE_W'(0));
    check("rst_line", refill_line, '0);

    // Basic fill, refill must appear the cycle after the rlast beat
    mshr_valid   = 4'b0100;
    mshr_no_resp = 4'b0000;
    send_line(2'd2, 64'h1000, N_BEAT, 1'b1, 1'b0, 1'b1, 1'b1);
    finish_refill(waited);
    check("refill_latency", LINE_W'(waited), LINE_W'(0));

    // Back-pressure on both handshakes while the next line's first beat waits
    mshr_valid = 4'b1111;
    send_line(2'd0, 64'h2000, N_BEAT, 1'b1, 1'b0, 1'b1, 1'b1);
    head         = sb[0];
    mshr_no_resp = 4'b0010;
    rvalid = 1'b1;
    rid    = 2'd1;
    rdata  = 64'h3000;
    rlast  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_refill_valid", LINE_W'(refill_valid), LINE_W'(1));
      check("bp_refill_rready", LINE_W'(rready), LINE_W'(0));
      check("bp_refill_line", refill_line, head.line);
      check("bp_refill_id", LINE_W'(refill_id), LINE_W'(head.id));
      tick();
    end
    void'(sb.pop_front());
    check("bp_no_resp", LINE_W'(refill_no_resp), LINE_W'(0));
    refill_ready = 1'b1;
    tick();
    refill_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_dealloc_valid", LINE_W'(dealloc_valid), LINE_W'(1));
      check("bp_dealloc_idx", LINE_W'(dealloc_idx), LINE_W'(0));
      check("bp_dealloc_rready", LINE_W'(rready), LINE_W'(0));
      tick();
    end
    dealloc_ready = 1'b1;
    tick();
    dealloc_ready = 1'b0;
    check("bp_idle_rready", LINE_W'(rready), LINE_W'(1));
    check("bp_idle_dealloc", LINE_W'(dealloc_valid), LINE_W'(0));

    // Flushed entry: the held beat is accepted at the next edge and the line completes
    send_line(2'd1, 64'h3000, N_BEAT, 1'b1, 1'b1, 1'b1, 1'b1);
    finish_refill(waited);
    check("flush_latency", LINE_W'(waited), LINE_W'(0));
    mshr_no_resp = 4'b0000;

    // Orphan response: refilled but never deallocated
    mshr_valid = 4'b0111;
    send_line(2'd3, 64'h4000, N_BEAT, 1'b1, 1'b0, 1'b0, 1'b1);
    finish_refill(waited);
    tick();
    check("orphan_no_dealloc", LINE_W'(dealloc_valid), LINE_W'(0));
    mshr_valid = 4'b1111;

`ifdef RVH_L1D_REFILL_BEAT_CHK_EN
    // Early rlast: tail slots zero, error flag raised
    send_line(2'd0, 64'h5000, 5, 1'b1, 1'b0, 1'b1, 1'b1);
    finish_refill(waited);
    check("early_rlast_err", LINE_W'(refill_err), LINE_W'(1));
`else
    check("err_tied_low", LINE_W'(refill_err), LINE_W'(0));
`endif

    // Reset in the middle of collection discards the partial line
    send_line(2'd2, 64'h6000, 3, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_refill", LINE_W'(refill_valid), LINE_W'(0));
    check("mid_rst_dealloc", LINE_W'(dealloc_valid), LINE_W'(0));
    check("mid_rst_rready", LINE_W'(rready), LINE_W'(1));
    check("mid_rst_err", LINE_W'(refill_err), LINE_W'(0));
    tick();
    tick();
    check("mid_rst_quiet", LINE_W'(refill_valid | dealloc_valid), LINE_W'(0));
    send_line(2'd2, 64'h7000, N_BEAT, 1'b1, 1'b0, 1'b1, 1'b1);
    finish_refill(waited);
    check("post_rst_latency", LINE_W'(waited), LINE_W'(0));

    check("sb_drained", LINE_W'(sb.size()), LINE_W'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
